ps2_key_tracker: RTL and testbench

//  Receives PS/2 keyboard frames on ps2_clk/ps2_data, oversampled on the system clk.

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_rx.sv | 104 ++++++++++
 rtl/ps2_key_tracker.sv | 111 +++++++++++
 tb/tb_ps2_key_tracker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and key-tracker state encoding for the PS/2 keyboard path.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam int         FRAME_LEN = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_BREAK = 2'd2
  } key_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge sampling, 11-bit framing
// with odd-parity check, and an inactivity timeout that aborts partial frames.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   prev_clk_q, prev_clk_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic sync_clk, sync_data, fall, frame_ok;

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign fall      = prev_clk_q & ~sync_clk;
  // shift_q holds start at [0], data at [8:1], parity at [9]; stop is the live sample.
  assign frame_ok  = ~shift_q[0] & sync_data & (^shift_q[9:1]);

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    prev_clk_d  = sync_clk;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    to_cnt_d    = to_cnt_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          rx_byte_d  = shift_q[8:1];
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {sync_data, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      // A fall in the same cycle wins, so the abort only happens on an idle cycle.
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = 4'd0;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Idle PS/2 lines are high; starting high avoids a false fall after reset.
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      prev_clk_q  <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      prev_clk_q  <= prev_clk_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Single-key tracker: follows make / typematic / E0 / F0 sequences from the PS/2
// receiver and presents the held scancode and a press counter to the display stage.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       ext,
  output logic       key_down,
  output logic [7:0] press_cnt,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  key_state_e state_q, state_d;
  logic [7:0] scancode_q, scancode_d;
  logic       ext_q, ext_d;
  logic       key_down_q, key_down_d;
  logic [7:0] press_cnt_q, press_cnt_d;
  logic       ext_pend_q, ext_pend_d;
  logic       same_key;

  ps2_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  assign same_key = (rx_byte == scancode_q) && (ext_pend_q == ext_q);

  always_comb begin
    state_d     = state_q;
    scancode_d  = scancode_q;
    ext_d       = ext_q;
    key_down_d  = key_down_q;
    press_cnt_d = press_cnt_q;
    ext_pend_d  = ext_pend_q;

    if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        case (state_q)
          ST_BREAK: begin
            ext_pend_d = 1'b0;
            if (same_key) begin
              key_down_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              state_d = key_down_q ? ST_HELD : ST_IDLE;
            end
          end
          ST_IDLE, ST_HELD: begin
            // F0 is a prefix like E0, so an E0 F0 xx release keeps its extended flag.
            if (rx_byte == PS2_BREAK) begin
              state_d = ST_BREAK;
            end else begin
              ext_pend_d = 1'b0;
              if (state_q == ST_IDLE || !same_key) begin
                scancode_d  = rx_byte;
                ext_d       = ext_pend_q;
                key_down_d  = 1'b1;
                press_cnt_d = press_cnt_q + 8'd1;
                state_d     = ST_HELD;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scancode_q  <= 8'h00;
      ext_q       <= 1'b0;
      key_down_q  <= 1'b0;
      press_cnt_q <= 8'h00;
      ext_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      scancode_q  <= scancode_d;
      ext_q       <= ext_d;
      key_down_q  <= key_down_d;
      press_cnt_q <= press_cnt_d;
      ext_pend_q  <= ext_pend_d;
    end
  end

  assign scancode  = scancode_q;
  assign ext       = ext_q;
  assign key_down  = key_down_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: bit-level PS/2 driver, key-tracking reference model,
// directed scenarios plus randomized byte streams with corrupted frames mixed in.
module tb_ps2_key_tracker;

  localparam int TO   = 5000;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       ext;
  logic       key_down;
  logic [7:0] press_cnt;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scancode  (scancode),
    .ext       (ext),
    .key_down  (key_down),
    .press_cnt (press_cnt),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  // Pulse monitor, sampled away from the active edge.
  int         rv_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] last_rx = 8'h00;
  always @(negedge clk) begin
    if (rx_valid) begin
      rv_cnt  <= rv_cnt + 1;
      last_rx <= rx_byte;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  // Reference model of the key tracking rules.
  logic [7:0] m_scan, m_cnt;
  bit         m_ext, m_down, m_brk, m_pend;

  task automatic m_reset();
    m_scan = 8'h00; m_cnt = 8'h00;
    m_ext = 0; m_down = 0; m_brk = 0; m_pend = 0;
  endtask

  task automatic m_apply(input logic [7:0] b);
    bit same;
    same = (b == m_scan) && (m_pend == m_ext);
    if (b == 8'hE0) begin
      m_pend = 1;
    end else if (m_brk) begin
      if (same) m_down = 0;
      m_brk  = 0;
      m_pend = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!m_down || !same) begin
        m_scan = b;
        m_ext  = m_pend;
        m_down = 1;
        m_cnt  = m_cnt + 8'd1;
      end
      m_pend = 0;
    end
  endtask

  // Driver tasks.
  task automatic ps2_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
  endtask

  function automatic logic [10:0] make_bits(input logic [7:0] b, input bit bad_par,
                                            input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bits(make_bits(b, bad_par, bad_stop), 11);
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
  endtask

  // Tests.
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({scancode, ext, key_down, press_cnt, rx_byte, rx_valid, frame_err} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sc=%h ext=%b kd=%b pc=%h rx=%h rv=%b fe=%b, want all 0",
               scancode, ext, key_down, press_cnt, rx_byte, rx_valid, frame_err);
    end
  endtask

  task automatic test_make();
    int rv0;
    do_reset();
    rv0 = rv_cnt;
    send_frame(8'h1C, 0, 0); m_apply(8'h1C);
    n_cmp++;
    if (rv_cnt - rv0 !== 1 || last_rx !== 8'h1C) begin
      n_fail++;
      $display("FAIL make_rx: got %0d pulses byte %h, want 1 pulse byte 1c", rv_cnt - rv0, last_rx);
    end
    n_cmp++;
    if ({scancode, key_down, press_cnt} !== {8'h1C, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL make_key: got sc=%h kd=%b pc=%0d, want sc=1c kd=1 pc=1",
               scancode, key_down, press_cnt);
    end
  endtask

  task automatic test_repeat_break();
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i], 0, 0); m_apply(seq[i]);
      n_cmp++;
      if ({scancode, ext, key_down, press_cnt} !== {m_scan, m_ext, m_down, m_cnt}) begin
        n_fail++;
        $display("FAIL repeat_step%0d: got sc=%h ext=%b kd=%b pc=%0d, want sc=%h ext=%b kd=%b pc=%0d",
                 i, scancode, ext, key_down, press_cnt, m_scan, m_ext, m_down, m_cnt);
      end
    end
    n_cmp++;
    if ({scancode, key_down, press_cnt} !== {8'h1C, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL repeat_release: got sc=%h kd=%b pc=%0d, want sc=1c kd=0 pc=1",
               scancode, key_down, press_cnt);
    end
  endtask

  task automatic test_new_key();
    logic [7:0] seq [4] = '{8'h1C, 8'h32, 8'hF0, 8'h1C};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 0, 0); m_apply(seq[i]);
      if (i == 1) begin
        n_cmp++;
        if ({scancode, key_down, press_cnt} !== {8'h32, 1'b1, 8'd2}) begin
          n_fail++;
          $display("FAIL new_key: got sc=%h kd=%b pc=%0d, want sc=32 kd=1 pc=2",
                   scancode, key_down, press_cnt);
        end
      end
    end
    n_cmp++;
    if ({scancode, key_down, press_cnt} !== {8'h32, 1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL other_release: got sc=%h kd=%b pc=%0d, want sc=32 kd=1 pc=2",
               scancode, key_down, press_cnt);
    end
  endtask

  task automatic test_ext();
    logic [7:0] seq [7] = '{8'hE0, 8'h75, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_frame(seq[i], 0, 0); m_apply(seq[i]);
      if (i == 3) begin
        n_cmp++;
        if ({scancode, ext, key_down} !== {8'h75, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL ext_plain_break: got sc=%h ext=%b kd=%b, want sc=75 ext=1 kd=1",
                   scancode, ext, key_down);
        end
      end
    end
    n_cmp++;
    if ({scancode, ext, key_down, press_cnt} !== {8'h75, 1'b1, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL ext_release: got sc=%h ext=%b kd=%b pc=%0d, want sc=75 ext=1 kd=0 pc=1",
               scancode, ext, key_down, press_cnt);
    end
  endtask

  task automatic test_frame_errors();
    int rv0, fe0;
    do_reset();
    send_frame(8'h32, 0, 0); m_apply(8'h32);
    for (int k = 0; k < 2; k++) begin
      rv0 = rv_cnt; fe0 = fe_cnt;
      send_frame(8'h1C, k == 0, k == 1);
      n_cmp++;
      if (rv_cnt - rv0 !== 0 || fe_cnt - fe0 !== 1) begin
        n_fail++;
        $display("FAIL bad_frame%0d: got rv=%0d fe=%0d, want rv=0 fe=1", k, rv_cnt - rv0, fe_cnt - fe0);
      end
      n_cmp++;
      if ({scancode, ext, key_down, press_cnt} !== {m_scan, m_ext, m_down, m_cnt}) begin
        n_fail++;
        $display("FAIL bad_frame_hold%0d: got sc=%h kd=%b pc=%0d, want sc=%h kd=%b pc=%0d",
                 k, scancode, key_down, press_cnt, m_scan, m_down, m_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    int rv0, fe0;
    do_reset();
    rv0 = rv_cnt; fe0 = fe_cnt;
    ps2_bits(make_bits(8'h5A, 0, 0), 4);
    repeat (TO - 100) @(negedge clk);
    n_cmp++;
    if (fe_cnt - fe0 !== 0) begin
      n_fail++;
      $display("FAIL timeout_early: got fe=%0d before limit, want 0", fe_cnt - fe0);
    end
    repeat (150) @(negedge clk);
    n_cmp++;
    if (fe_cnt - fe0 !== 1 || rv_cnt - rv0 !== 0) begin
      n_fail++;
      $display("FAIL timeout_abort: got fe=%0d rv=%0d, want fe=1 rv=0", fe_cnt - fe0, rv_cnt - rv0);
    end
    send_frame(8'h32, 0, 0); m_apply(8'h32);
    n_cmp++;
    if (rv_cnt - rv0 !== 1 || last_rx !== 8'h32 || scancode !== 8'h32 || press_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL timeout_recover: got rv=%0d rx=%h sc=%h pc=%0d, want rv=1 rx=32 sc=32 pc=1",
               rv_cnt - rv0, last_rx, scancode, press_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rv0;
    do_reset();
    send_frame(8'h1C, 0, 0);
    ps2_bits(make_bits(8'h5A, 0, 0), 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({scancode, ext, key_down, press_cnt, rx_byte, rx_valid, frame_err} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got sc=%h kd=%b pc=%h rx=%h, want all 0", scancode, key_down,
               press_cnt, rx_byte);
    end
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rv0 = rv_cnt;
    send_frame(8'h32, 0, 0); m_apply(8'h32);
    n_cmp++;
    if (rv_cnt - rv0 !== 1 || scancode !== 8'h32 || key_down !== 1'b1 || press_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_recover: got rv=%0d sc=%h kd=%b pc=%0d, want rv=1 sc=32 kd=1 pc=1",
               rv_cnt - rv0, scancode, key_down, press_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      b = i[0] ? 8'h32 : 8'h1C;
      send_frame(b, 0, 0); m_apply(b);
    end
    n_cmp++;
    if (press_cnt !== 8'd0 || press_cnt !== m_cnt || scancode !== 8'h32) begin
      n_fail++;
      $display("FAIL press_wrap: got pc=%0d sc=%h, want pc=0 sc=32", press_cnt, scancode);
    end
  endtask

  task automatic test_random();
    logic [7:0] tbl [6] = '{8'h1C, 8'h32, 8'h75, 8'h5A, 8'hE0, 8'hF0};
    logic [7:0] b;
    int rv0, fe0;
    bit bad;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      b   = tbl[$urandom_range(0, 5)];
      bad = ($urandom_range(0, 7) == 0);
      rv0 = rv_cnt; fe0 = fe_cnt;
      send_frame(b, bad, 0);
      if (!bad) m_apply(b);
      n_cmp++;
      if ((rv_cnt - rv0) !== (bad ? 0 : 1) || (fe_cnt - fe0) !== (bad ? 1 : 0) ||
          {scancode, ext, key_down, press_cnt} !== {m_scan, m_ext, m_down, m_cnt}) begin
        n_fail++;
        $display("FAIL random%0d byte %h bad=%b: got rv=%0d fe=%0d sc=%h ext=%b kd=%b pc=%0d, want sc=%h ext=%b kd=%b pc=%0d",
                 i, b, bad, rv_cnt - rv0, fe_cnt - fe0, scancode, ext, key_down, press_cnt,
                 m_scan, m_ext, m_down, m_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    test_reset();
    test_make();
    test_repeat_break();
    test_new_key();
    test_ext();
    test_frame_errors();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
